// File: rtl/ser_tx_gw_if.sv
// ser_tx_gw_if: load handshake and serial output bundle for ser_tx_gw.
// The master is the word source and serial consumer. The slave is the transmitter.
interface ser_tx_gw_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] D;
  logic             LOAD_VLD;
  logic             LOAD_RDY;
  logic             Q;
  logic             Q_VLD;
  logic             BUSY;

  modport master (
    output D,
    output LOAD_VLD,
    input  LOAD_RDY,
    input  Q,
    input  Q_VLD,
    input  BUSY
  );

  modport slave (
    input  D,
    input  LOAD_VLD,
    output LOAD_RDY,
    output Q,
    output Q_VLD,
    output BUSY
  );
endinterface

// File: rtl/ser_tx_gw.sv
// ser_tx_gw: single-clock parallel-to-serial transmitter with a valid/ready load port.
// It shifts one bit per CLK on a registered Q. A new word can be accepted during the
// final bit of the current word, so consecutive words leave no gap. Q idles at INIT.
// Optional feature: define SER_TX_PARITY_EN to append an even-parity bit to every word.
module ser_tx_gw #(
  parameter int   WIDTH     = 4,
  parameter int   LSB_FIRST = 1,
  parameter logic INIT      = 1'b1
) (
  input  logic       CLK,
  input  logic       RESETN,
  ser_tx_gw_if.slave bus
);

`ifdef SER_TX_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(NBITS - 1);
`ifdef SER_TX_PARITY_EN
  localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             q_r;
  logic             load_rdy;
  logic             xfer;
  logic             last_bit;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] shift_rest;
`ifdef SER_TX_PARITY_EN
  logic             par_r;
`endif

  assign last_bit = (state == SHIFT) && (cnt == LAST_BIT);
  assign xfer     = bus.LOAD_VLD && load_rdy;

  // State register; reset drops any word in flight and returns to IDLE.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_next;
  end

  // Next state: leave IDLE on a transfer, leave SHIFT only when the last bit finds no new word.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (xfer) state_next = SHIFT;
      SHIFT: if (last_bit && !xfer) state_next = IDLE;
    endcase
  end

  // Outputs: ready in IDLE or on the last bit, and never while reset is held.
  always_comb begin
    load_rdy  = 1'b0;
    if (RESETN) load_rdy = (state == IDLE) || last_bit;
    bus.LOAD_RDY = load_rdy;
    bus.Q        = q_r;
    bus.Q_VLD    = (state == SHIFT);
    bus.BUSY     = (state == SHIFT);
  end

  // Bit-order steering: the first bit comes straight from D, and later bits come from the shifter, which fills with INIT.
  always_comb begin
    if (LSB_FIRST != 0) begin
      first_bit  = bus.D[0];
      load_rest  = {INIT, bus.D[WIDTH-1:1]};
      next_bit   = shreg[0];
      shift_rest = {INIT, shreg[WIDTH-1:1]};
    end else begin
      first_bit  = bus.D[WIDTH-1];
      load_rest  = {bus.D[WIDTH-2:0], INIT};
      next_bit   = shreg[WIDTH-1];
      shift_rest = {shreg[WIDTH-2:0], INIT};
    end
`ifdef SER_TX_PARITY_EN
    if (cnt == LAST_DATA) next_bit = par_r;
`endif
  end

  // Datapath: load on a transfer, advance one bit per cycle in SHIFT, and return Q to INIT after the last bit.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      q_r   <= INIT;
      shreg <= '0;
      cnt   <= '0;
`ifdef SER_TX_PARITY_EN
      par_r <= 1'b0;
`endif
    end else if (xfer) begin
      q_r   <= first_bit;
      shreg <= load_rest;
      cnt   <= '0;
`ifdef SER_TX_PARITY_EN
      par_r <= ^bus.D;
`endif
    end else if (state == SHIFT) begin
      if (last_bit) begin
        q_r <= INIT;
        cnt <= '0;
      end else begin
        q_r   <= next_bit;
        shreg <= shift_rest;
        cnt   <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ser_tx_gw.sv
// tb_ser_tx_gw: directed bench for ser_tx_gw.
// It drives one LSB-first DUT and one MSB-first DUT from the same load stimulus.
// Expected serial bits are derived from the word being sent.
// If SER_TX_PARITY_EN is defined, the bench also expects the parity bit.
module tb_ser_tx_gw;

`ifdef SER_TX_PARITY_EN
  localparam int NBITS = 5;
`else
  localparam int NBITS = 4;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  ser_tx_gw_if #(.WIDTH(4)) bus_l ();
  ser_tx_gw_if #(.WIDTH(4)) bus_m ();

  ser_tx_gw #(.WIDTH(4), .LSB_FIRST(1), .INIT(1'b1)) dut_l (
    .CLK(clk), .RESETN(rst_n), .bus(bus_l)
  );
  ser_tx_gw #(.WIDTH(4), .LSB_FIRST(0), .INIT(1'b1)) dut_m (
    .CLK(clk), .RESETN(rst_n), .bus(bus_m)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_load(input logic vld, input logic [3:0] w);
    bus_l.LOAD_VLD = vld;
    bus_m.LOAD_VLD = vld;
    bus_l.D = w;
    bus_m.D = w;
  endtask

  task automatic check_idle(input string tag, input logic rdy);
    checkOutput({tag, "_q_l"},   {15'd0, bus_l.Q},        16'd1);
    checkOutput({tag, "_q_m"},   {15'd0, bus_m.Q},        16'd1);
    checkOutput({tag, "_qvld"},  {15'd0, bus_l.Q_VLD},    16'd0);
    checkOutput({tag, "_busy"},  {15'd0, bus_l.BUSY},     16'd0);
    checkOutput({tag, "_rdy_l"}, {15'd0, bus_l.LOAD_RDY}, {15'd0, rdy});
    checkOutput({tag, "_rdy_m"}, {15'd0, bus_m.LOAD_RDY}, {15'd0, rdy});
  endtask

  // mode 0: drop LOAD_VLD after the transfer; 1: chain nxt; 2: stall with nxt, then drop on last bit
  task automatic applyStimulus(input logic [3:0] w, input logic [3:0] nxt, input int mode);
    logic exp_l;
    logic exp_m;
    set_load(1'b1, w);
    #1;
    checkOutput($sformatf("rdy_pre_%h", w), {15'd0, bus_l.LOAD_RDY}, 16'd1);
    tick();
    if (mode == 0) set_load(1'b0, w);
    else           set_load(1'b1, nxt);
    for (int i = 0; i < NBITS; i++) begin
      if (i < 4) begin
        exp_l = w[i];
        exp_m = w[3 - i];
      end else begin
        exp_l = ^w;
        exp_m = ^w;
      end
      checkOutput($sformatf("w%h_b%0d_q_l", w, i), {15'd0, bus_l.Q}, {15'd0, exp_l});
      checkOutput($sformatf("w%h_b%0d_q_m", w, i), {15'd0, bus_m.Q}, {15'd0, exp_m});
      checkOutput($sformatf("w%h_b%0d_qvld", w, i), {15'd0, bus_l.Q_VLD}, 16'd1);
      checkOutput($sformatf("w%h_b%0d_busy", w, i), {15'd0, bus_m.BUSY}, 16'd1);
      checkOutput($sformatf("w%h_b%0d_rdy", w, i), {15'd0, bus_l.LOAD_RDY},
                  (i == NBITS - 1) ? 16'd1 : 16'd0);
      if (i == NBITS - 1 && mode == 2) set_load(1'b0, nxt);
      if (i < NBITS - 1) tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    set_load(1'b0, 4'h0);

    repeat (3) @(negedge clk);
    check_idle("reset", 1'b0);
    rst_n = 1'b1;
    #1;
    checkOutput("rdy_after_release", {15'd0, bus_l.LOAD_RDY}, 16'd1);

    $display("[TB] single words");
    applyStimulus(4'b1010, 4'h0, 0);
    tick();
    check_idle("after_1010", 1'b1);
    applyStimulus(4'b1100, 4'h0, 0);
    tick();
    check_idle("after_1100", 1'b1);
    applyStimulus(4'b0111, 4'h0, 0);
    tick();
    check_idle("after_0111", 1'b1);

    $display("[TB] back-to-back");
    applyStimulus(4'hA, 4'h5, 1);
    applyStimulus(4'h5, 4'h0, 0);
    tick();
    check_idle("after_b2b", 1'b1);

    $display("[TB] stall with changing D");
    applyStimulus(4'b0110, 4'b1001, 2);
    tick();
    check_idle("after_stall", 1'b1);

    $display("[TB] reset mid-word");
    set_load(1'b1, 4'b1010);
    tick();
    set_load(1'b0, 4'b1010);
    checkOutput("rst_mid_b0", {15'd0, bus_l.Q}, 16'd0);
    tick();
    checkOutput("rst_mid_b1", {15'd0, bus_l.Q}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle("rst_mid", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rdy_after_mid_rst", {15'd0, bus_m.LOAD_RDY}, 16'd1);
    @(negedge clk);
    applyStimulus(4'b0011, 4'h0, 0);
    tick();
    check_idle("after_recover", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
